relu_maxpool2x2: RTL and testbench
==================================

// Module: relu_maxpool2x2
// PURPOSE
//  Downstream stage of the convolution engine. Consumes the raster-order stream of conv sums.
//  Applies ReLU, then requantizes to 8 bits (shift + saturate), then does 2x2/stride-2 max-pooling.
//  Writes each pooled byte to destination memory at consecutive addresses from a start address.
//  Uses a half-width line buffer to hold per-column-pair maxima of the even row.
// PARAMETERS
//  ACC_W   16  width of signed conv sum input
//  IMG_W   26  conv output columns per row (28-3+1)
//  IMG_H   26  conv output rows per frame
//  SHIFT   0   arithmetic right shift applied after ReLU, before saturation
//  ADDR_W  10  destination address width
// PORTS
//  i_clk             in   1       clock, rising edge
//  i_rst_n           in   1       asynchronous active-low reset
//  i_start           in   1       start a frame; sampled only in IDLE
//  i_dst_start_addr  in   ADDR_W  first pooled-output address; latched on accepted i_start
//  i_valid           in   1       i_data holds a valid conv sum
//  o_ready           out  1       block accepts i_data this cycle
//  i_data            in   ACC_W   signed conv sum, raster order (row-major)
//  o_wr_en           out  1       one-cycle write strobe
//  o_wr_addr         out  ADDR_W  destination address
//  o_wr_data         out  8       pooled unsigned byte
//  o_busy            out  1       high from accepted i_start until o_done
//  o_done            out  1       one-cycle pulse at frame end
// BEHAVIOUR
//  Reset: state=IDLE; counters, line buffer index and all outputs = 0. Line buffer contents are don't-care.
//  FSM:
//   IDLE -> RUN on i_start. Latch i_dst_start_addr; clear row r and column c. Assert o_busy.
//   RUN: accept a pixel when i_valid && o_ready. o_ready=1 only in RUN. i_valid outside RUN is ignored.
//   RUN -> DONE on acceptance of pixel (r=IMG_H-1, c=IMG_W-1).
//   DONE: o_done=1 for one cycle, o_busy=0, then IDLE.
//   i_start outside IDLE is ignored.
//  Per accepted pixel x: y = min(max(x,0) >>> SHIFT, 255).
//   Comparisons are unsigned 8-bit on y.
//  Horizontal pairing:
//   even c: hold y in register h.
//   odd c: hm = max(h, y).
//  Vertical pairing (k = c>>1):
//   even r, odd c: lb[k] = hm.
//   odd r, odd c: issue a write of max(lb[k], hm).
//  Write timing: registered. o_wr_en, addr and data appear the cycle after the pixel completing the 2x2 window is accepted.
//   Address starts at the latched start address and increments by 1 per write, no wrap check.
//   Address wraps modulo 2^ADDR_W.
//  Odd IMG_W: last column is accepted and discarded. Odd IMG_H: last row is accepted and discarded.
//   Total writes = (IMG_W/2)*(IMG_H/2), floor division.
//  o_done is asserted the cycle after the final pixel is accepted.
//   This coincides with the final o_wr_en when one is produced.
//  Counter wrap: c wraps IMG_W-1 -> 0 and increments r.
//  No throughput loss: one pixel per cycle is sustained, and gaps in i_valid are tolerated.
//  Reset mid-frame: everything returns to the reset state immediately. Writes already issued stand.
//   The next i_start begins a clean frame.
// TESTING
//  1. Hold i_rst_n=0 with random inputs
//     -> o_wr_en=o_busy=o_done=o_ready=0, o_wr_addr=0, o_wr_data=0.
//  2. IMG_W=IMG_H=4, SHIFT=0, dst=0x100, data 1..16 raster, i_valid const 1
//     -> writes (0x100,6) (0x101,8) (0x102,14) (0x103,16); o_done with last write.
//  3. Same frame, all inputs -5 -> four writes of 0.
//     Input 300 at SHIFT=0 -> 255.
//     SHIFT=2: 400 -> 100, 1023 -> 255.
//  4. Repeat test 2 with random i_valid gaps -> identical write sequence.
//     No write or state change on i_valid=0 cycles.
//  5. IMG_W=IMG_H=5, data 1..25 -> writes 7,9,17,19 at dst..dst+3.
//     o_done the cycle after the 25th pixel is accepted, with no write that cycle.
//  6. Drop i_rst_n after 7 pixels of test 2, then restart with i_start
//     -> outputs clear; new frame reproduces the test 2 results exactly.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
// ReLU + shift/saturate requantization followed by 2x2 stride-2 max-pooling of a raster stream.
// Pooled bytes are written to consecutive destination addresses starting at a latched base.
module relu_maxpool2x2 #(
    parameter int ACC_W  = 16,
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26,
    parameter int SHIFT  = 0,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_dst_start_addr,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ACC_W-1:0]  i_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_done
);
    // state | meaning
    // IDLE  | waiting for i_start
    // RUN   | accepting pixels, one per cycle when i_valid
    // DONE  | one-cycle o_done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW  = $clog2(IMG_W + 1);
    localparam int RW  = $clog2(IMG_H + 1);
    localparam int LBN = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int KW  = ($clog2(LBN) > 0) ? $clog2(LBN) : 1;

    state_t            state_q;
    logic [CW-1:0]     c_q;
    logic [RW-1:0]     r_q;
    logic [7:0]        h_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        lb_q [LBN];

    logic              accept;
    logic [ACC_W-1:0]  shifted;
    logic [7:0]        pix_y;
    logic [7:0]        hmax;
    logic [7:0]        pool_max;
    logic [KW-1:0]     k;
    logic              last_col;
    logic              last_pix;

    assign accept   = (state_q == RUN) && i_valid;
    assign shifted  = i_data >> SHIFT;
    assign k        = KW'(c_q >> 1);
    assign last_col = (c_q == CW'(IMG_W - 1));
    assign last_pix = last_col && (r_q == RW'(IMG_H - 1));

    // Sign bit set means negative: ReLU clamps to zero before the shift matters.
    always_comb begin
        pix_y = shifted[7:0];
        if (i_data[ACC_W-1]) begin
            pix_y = 8'd0;
        end else if (shifted > ACC_W'(255)) begin
            pix_y = 8'hFF;
        end
    end

    assign hmax     = (h_q > pix_y) ? h_q : pix_y;
    assign pool_max = (lb_q[k] > hmax) ? lb_q[k] : hmax;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            r_q       <= '0;
            h_q       <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= RUN;
                        addr_q  <= i_dst_start_addr;
                        c_q     <= '0;
                        r_q     <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!c_q[0]) begin
                            h_q <= pix_y;
                        end else if (r_q[0]) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= pool_max;
                            addr_q    <= addr_q + 1'b1;
                        end
                        if (last_col) begin
                            c_q <= '0;
                            r_q <= r_q + 1'b1;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                        if (last_pix) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (accept && c_q[0] && !r_q[0]) begin
            lb_q[k] <= hmax;
        end
    end

    assign o_ready   = (state_q == RUN);
    assign o_busy    = (state_q == RUN);
    assign o_done    = (state_q == DONE);
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Randomized bench for relu_maxpool2x2: three instances (4x4 shift 0, 5x5 shift 0, 4x4 shift 2)
// checked cycle by cycle against a window-max reference model.
module tb_relu_maxpool2x2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s   [3];
    logic [9:0]  dst_s     [3];
    logic        valid_s   [3];
    logic [15:0] data_s    [3];
    logic        ready_s   [3];
    logic        wr_en_s   [3];
    logic [9:0]  wr_addr_s [3];
    logic [7:0]  wr_data_s [3];
    logic        busy_s    [3];
    logic        done_s    [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    relu_maxpool2x2 #(.ACC_W(16), .IMG_W(4), .IMG_H(4), .SHIFT(0), .ADDR_W(10)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[0]), .i_dst_start_addr(dst_s[0]),
        .i_valid(valid_s[0]), .o_ready(ready_s[0]), .i_data(data_s[0]), .o_wr_en(wr_en_s[0]),
        .o_wr_addr(wr_addr_s[0]), .o_wr_data(wr_data_s[0]), .o_busy(busy_s[0]), .o_done(done_s[0]));
    relu_maxpool2x2 #(.ACC_W(16), .IMG_W(5), .IMG_H(5), .SHIFT(0), .ADDR_W(10)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[1]), .i_dst_start_addr(dst_s[1]),
        .i_valid(valid_s[1]), .o_ready(ready_s[1]), .i_data(data_s[1]), .o_wr_en(wr_en_s[1]),
        .o_wr_addr(wr_addr_s[1]), .o_wr_data(wr_data_s[1]), .o_busy(busy_s[1]), .o_done(done_s[1]));
    relu_maxpool2x2 #(.ACC_W(16), .IMG_W(4), .IMG_H(4), .SHIFT(2), .ADDR_W(10)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[2]), .i_dst_start_addr(dst_s[2]),
        .i_valid(valid_s[2]), .o_ready(ready_s[2]), .i_data(data_s[2]), .o_wr_en(wr_en_s[2]),
        .o_wr_addr(wr_addr_s[2]), .o_wr_data(wr_data_s[2]), .o_busy(busy_s[2]), .o_done(done_s[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic int yof(input int x, input int s);
        int v;
        if (x < 0) return 0;
        v = x >>> s;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            dst_s[i]   = '0;
            valid_s[i] = 1'b0;
            data_s[i]  = '0;
        end
    endtask

    task automatic chk_reset_outputs(input int u);
        chk("rst_wr_en", wr_en_s[u], 0);
        chk("rst_busy", busy_s[u], 0);
        chk("rst_done", done_s[u], 0);
        chk("rst_ready", ready_s[u], 0);
        chk("rst_wr_addr", wr_addr_s[u], 0);
        chk("rst_wr_data", wr_data_s[u], 0);
    endtask

    // Drives one frame into instance u and checks every cycle; abort_n>0 stops after that many pixels.
    task automatic run_frame(input int u, input int w, input int h, input int s, input int pix[$],
                             input int dst, input int gap_pct, input int abort_n);
        int exp_a[$];
        int exp_d[$];
        int idx = 0, cyc = 0, m, r, c;
        bit exp_wr = 0, exp_done = 0, done_seen = 0, v;
        for (int pr = 0; pr < h / 2; pr++)
            for (int pc = 0; pc < w / 2; pc++) begin
                m = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        m = (yof(pix[(2*pr+dr)*w + 2*pc+dc], s) > m) ? yof(pix[(2*pr+dr)*w + 2*pc+dc], s) : m;
                exp_a.push_back((dst + exp_a.size()) % 1024);
                exp_d.push_back(m);
            end
        @(negedge clk);
        start_s[u] = 1'b1;
        dst_s[u]   = dst[9:0];
        @(negedge clk);
        start_s[u] = 1'b0;
        dst_s[u]   = 10'($urandom);
        chk("busy_after_start", busy_s[u], 1);
        chk("ready_after_start", ready_s[u], 1);
        while (!done_seen && cyc < 20 * w * h + 20) begin
            chk("wr_en", wr_en_s[u], exp_wr);
            if (wr_en_s[u] && exp_a.size() > 0) begin
                chk("wr_addr", wr_addr_s[u], exp_a.pop_front());
                chk("wr_data", wr_data_s[u], exp_d.pop_front());
            end
            chk("done", done_s[u], exp_done);
            if (done_s[u]) begin
                done_seen = 1;
                chk("busy_at_done", busy_s[u], 0);
                chk("ready_at_done", ready_s[u], 0);
            end
            exp_wr   = 0;
            exp_done = 0;
            start_s[u] = 1'($urandom);
            if (!done_seen && idx < w * h) begin
                v = ($urandom_range(99) >= gap_pct);
                valid_s[u] = v;
                data_s[u]  = v ? 16'(pix[idx]) : 16'($urandom);
                if (v && ready_s[u]) begin
                    r = idx / w;
                    c = idx % w;
                    exp_wr   = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2));
                    exp_done = (idx == w * h - 1);
                    idx++;
                end
            end else begin
                valid_s[u] = 1'b0;
            end
            if (abort_n > 0 && idx >= abort_n) begin
                @(negedge clk);
                idle_all();
                return;
            end
            @(negedge clk);
            cyc++;
        end
        idle_all();
        if (!done_seen) chk("frame_timeout", 0, 1);
        chk("writes_outstanding", exp_a.size(), 0);
    endtask

    initial begin
        int pix[$];
        idle_all();
        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                start_s[j] = 1'($urandom);
                valid_s[j] = 1'($urandom);
                data_s[j]  = 16'($urandom);
                dst_s[j]   = 10'($urandom);
            end
        end
        for (int j = 0; j < 3; j++) chk_reset_outputs(j);
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;

        pix.delete();
        for (int i = 1; i <= 16; i++) pix.push_back(i);
        run_frame(0, 4, 4, 0, pix, 'h100, 0, 0);

        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(-5);
        run_frame(0, 4, 4, 0, pix, 'h2A0, 0, 0);
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(300);
        run_frame(0, 4, 4, 0, pix, 'h010, 0, 0);
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back((i % 3 == 0) ? 400 : ((i % 3 == 1) ? 1023 : -7));
        run_frame(2, 4, 4, 2, pix, 'h050, 0, 0);
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(400);
        run_frame(2, 4, 4, 2, pix, 'h060, 0, 0);

        pix.delete();
        for (int i = 1; i <= 16; i++) pix.push_back(i);
        run_frame(0, 4, 4, 0, pix, 'h100, 40, 0);

        pix.delete();
        for (int i = 1; i <= 25; i++) pix.push_back(i);
        run_frame(1, 5, 5, 0, pix, 'h200, 0, 0);
        run_frame(1, 5, 5, 0, pix, 'h3FE, 30, 0);

        pix.delete();
        for (int i = 1; i <= 16; i++) pix.push_back(i);
        run_frame(0, 4, 4, 0, pix, 'h100, 0, 7);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 4, 4, 0, pix, 'h100, 0, 0);

        for (int t = 0; t < 12; t++) begin
            int u, w, s;
            u = t % 3;
            w = (u == 1) ? 5 : 4;
            s = (u == 2) ? 2 : 0;
            pix.delete();
            for (int i = 0; i < w * w; i++) pix.push_back(int'($urandom_range(1600)) - 400);
            run_frame(u, w, w, s, pix, int'($urandom_range(1023)), int'($urandom_range(50)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
